// File: rtl/kenh_pkg.sv
// Shared types and constants for the kenh channel-scan sequencer.
package kenh_pkg;

  localparam int unsigned NCH     = 12;
  localparam int unsigned SELW    = 4;
  localparam int unsigned DWELL_W = 8;

  typedef logic [NCH-1:0]     mask_t;
  typedef logic [SELW-1:0]    sel_t;
  typedef logic [DWELL_W-1:0] dwell_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DWELL  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/kenh_next_find.sv
// Fixed-priority channel finder: lowest enabled channel overall and lowest
// enabled channel strictly above the current select.
module kenh_next_find
  import kenh_pkg::*;
(
  input  logic [NCH-1:0]  mask,
  input  logic [SELW-1:0] cur,
  output logic [SELW-1:0] first,
  output logic [SELW-1:0] next,
  output logic            has_next,
  output logic            any
);

  // Scan from the top down so the lowest matching index is the last one written.
  always_comb begin
    first    = '0;
    next     = '0;
    has_next = 1'b0;
    any      = |mask;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first = SELW'(i);
      end
      if (mask[i] && (SELW'(i) > cur)) begin
        next     = SELW'(i);
        has_next = 1'b1;
      end
    end
  end

endmodule

// File: rtl/kenh_scan_seq.sv
// Channel-scan sequencer: walks the mux select over enabled channels, dwells
// on each, samples mux bit 0, and publishes a snapshot per completed sweep.
module kenh_scan_seq
  import kenh_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [NCH-1:0]     ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               mux_in,
  output logic [SELW-1:0]    sel,
  output logic               sel_valid,
  output logic [NCH-1:0]     sample_vec,
  output logic               busy,
  output logic               done
);

  state_e      state_q, state_d;
  sel_t        sel_q, sel_d;
  logic        sel_valid_q, sel_valid_d;
  mask_t       sample_vec_q, sample_vec_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  mask_t       working_q, working_d;
  dwell_t      cnt_q, cnt_d;
  mask_t       mask_q, mask_d;
  dwell_t      dwell_q, dwell_d;
  logic        cont_q, cont_d;

  mask_t       find_mask_c;
  sel_t        fnd_first;
  sel_t        fnd_next;
  logic        fnd_has_next;
  logic        fnd_any;
  mask_t       merged_c;

  // Latch points (IDLE start, DONE wrap) search the live mask; mid-sweep uses the latched one.
  always_comb begin
    find_mask_c = mask_q;
    if ((state_q == IDLE) || (state_q == DONE)) begin
      find_mask_c = ch_mask;
    end
  end

  kenh_next_find u_find (
    .mask     (find_mask_c),
    .cur      (sel_q),
    .first    (fnd_first),
    .next     (fnd_next),
    .has_next (fnd_has_next),
    .any      (fnd_any)
  );

  // Working vector with the current channel's sample folded in.
  always_comb begin
    merged_c = working_q;
    for (int k = 0; k < int'(NCH); k++) begin
      if (sel_q == SELW'(k)) begin
        merged_c[k] = mux_in;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    sel_valid_d  = sel_valid_q;
    sample_vec_d = sample_vec_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    working_d    = working_q;
    cnt_d        = cnt_q;
    mask_d       = mask_q;
    dwell_d      = dwell_q;
    cont_d       = cont_q;

    unique case (state_q)
      IDLE: begin
        if (start && !stop && fnd_any) begin
          mask_d      = ch_mask;
          dwell_d     = dwell;
          cont_d      = continuous;
          working_d   = '0;
          sel_d       = fnd_first;
          cnt_d       = dwell;
          busy_d      = 1'b1;
          sel_valid_d = 1'b1;
          state_d     = DWELL;
        end
      end

      DWELL: begin
        if (stop) begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          sel_valid_d = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end

      SAMPLE: begin
        if (stop) begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          sel_valid_d = 1'b0;
        end else begin
          working_d = merged_c;
          if (fnd_has_next) begin
            sel_d   = fnd_next;
            cnt_d   = dwell_q;
            state_d = DWELL;
          end else begin
            // Snapshot and pulse are registered together so they appear in the DONE cycle.
            sample_vec_d = merged_c;
            done_d       = 1'b1;
            sel_valid_d  = 1'b0;
            state_d      = DONE;
          end
        end
      end

      DONE: begin
        if (stop || !cont_q || !fnd_any) begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          sel_valid_d = 1'b0;
        end else begin
          mask_d      = ch_mask;
          dwell_d     = dwell;
          working_d   = '0;
          sel_d       = fnd_first;
          cnt_d       = dwell;
          sel_valid_d = 1'b1;
          state_d     = DWELL;
        end
      end

      default: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        sel_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      sel_valid_q  <= 1'b0;
      sample_vec_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      working_q    <= '0;
      cnt_q        <= '0;
      mask_q       <= '0;
      dwell_q      <= '0;
      cont_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      sel_valid_q  <= sel_valid_d;
      sample_vec_q <= sample_vec_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      working_q    <= working_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      dwell_q      <= dwell_d;
      cont_q       <= cont_d;
    end
  end

  assign sel        = sel_q;
  assign sel_valid  = sel_valid_q;
  assign sample_vec = sample_vec_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_kenh_scan_seq.sv
// Scoreboard bench for kenh_scan_seq: stimulus pushes the expected select
// trace and sweep snapshots; monitors pop and compare as the DUT presents them.
module tb_kenh_scan_seq;
  import kenh_pkg::*;

  localparam int BIG = 1 << 30;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               continuous = 1'b0;
  logic [NCH-1:0]     ch_mask = '0;
  logic [DWELL_W-1:0] dwell_i = '0;
  logic               mux_in;
  logic [SELW-1:0]    sel;
  logic               sel_valid;
  logic [NCH-1:0]     sample_vec;
  logic               busy;
  logic               done;

  logic [15:0] pat = '0;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct { int cyc; logic [SELW-1:0] ch; } sel_exp_t;
  typedef struct { int cyc; logic [NCH-1:0] vec; } done_exp_t;
  sel_exp_t  selq[$];
  done_exp_t doneq[$];
  sel_exp_t  mon_se;
  done_exp_t mon_de;

  kenh_scan_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .ch_mask    (ch_mask),
    .dwell      (dwell_i),
    .mux_in     (mux_in),
    .sel        (sel),
    .sel_valid  (sel_valid),
    .sample_vec (sample_vec),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Downstream mux model: bit 0 of the selected channel's data pattern.
  assign mux_in = pat[sel];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: each enabled channel occupies dwell+2 cycles in ascending order;
  // the snapshot follows in the next cycle. Entries at offset >= limit are dropped.
  task automatic expect_sweep(input int e0, input logic [NCH-1:0] m, input int dw,
                              input logic [15:0] p, input int limit);
    int t = 0;
    sel_exp_t se;
    done_exp_t de;
    for (int ch = 0; ch < int'(NCH); ch++) begin
      if (m[ch]) begin
        for (int j = 0; j < dw + 2; j++) begin
          if (t < limit) begin
            se.cyc = e0 + t;
            se.ch  = SELW'(ch);
            selq.push_back(se);
          end
          t++;
        end
      end
    end
    if (t < limit) begin
      de.cyc = e0 + t;
      de.vec = m & p[NCH-1:0];
      doneq.push_back(de);
    end
  endtask

  task automatic issue_start(input logic [NCH-1:0] m, input int dw, input logic c, output int e0);
    @(negedge clk);
    ch_mask    = m;
    dwell_i    = DWELL_W'(dw);
    continuous = c;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e0    = cyc;
  endtask

  task automatic wait_cyc(input int x);
    while (cyc < x) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((selq.size() != 0 || doneq.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (selq.size() != 0 || doneq.size() != 0) begin
      check("drain_timeout", 32'(selq.size() + doneq.size()), 32'(0));
      selq.delete();
      doneq.delete();
    end
    @(negedge clk);
  endtask

  // Select-trace monitor.
  always @(negedge clk) begin
    if (rst_n && sel_valid) begin
      check("sel_range", 32'(sel >= SELW'(NCH)), 32'(0));
      if (selq.size() == 0) begin
        check("sel_valid_unexpected", 32'(sel_valid), 32'(0));
      end else begin
        mon_se = selq.pop_front();
        check("sel_cycle", 32'(cyc), 32'(mon_se.cyc));
        check("sel_value", 32'(sel), 32'(mon_se.ch));
      end
    end
  end

  // Sweep-snapshot monitor.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (doneq.size() == 0) begin
        check("done_unexpected", 32'(done), 32'(0));
      end else begin
        mon_de = doneq.pop_front();
        check("done_cycle", 32'(cyc), 32'(mon_de.cyc));
        check("sample_vec", 32'(sample_vec), 32'(mon_de.vec));
      end
    end
  end

  initial begin
    int e0;
    int dw;
    logic [NCH-1:0] m;
    logic [SELW-1:0] sel_prev;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_sel", 32'(sel), 32'(0));
    check("rst_sel_valid", 32'(sel_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_sample_vec", 32'(sample_vec), 32'(0));
    rst_n = 1'b1;

    // Single-shot, channels 0 and 2, only channel 2 reads high
    pat = 16'h0004;
    issue_start(12'h005, 3, 1'b0, e0);
    expect_sweep(e0, 12'h005, 3, pat, BIG);
    wait_cyc(e0 + 10);
    check("s1_busy_in_done", 32'(busy), 32'(1));
    wait_cyc(e0 + 11);
    check("s1_busy_after", 32'(busy), 32'(0));
    check("s1_sel_valid_after", 32'(sel_valid), 32'(0));
    check("s1_vec_hold", 32'(sample_vec), 32'(12'h004));
    drain();

    // All channels, zero dwell, odd channels read high
    pat = 16'hAAAA;
    issue_start(12'hFFF, 0, 1'b0, e0);
    expect_sweep(e0, 12'hFFF, 0, pat, BIG);
    drain();
    check("s2_vec", 32'(sample_vec), 32'(12'hAAA));
    check("s2_busy", 32'(busy), 32'(0));

    // Completed sweep, then a stopped sweep must keep the old snapshot
    pat = 16'h0009;
    issue_start(12'h00F, 2, 1'b0, e0);
    expect_sweep(e0, 12'h00F, 2, pat, BIG);
    drain();
    pat = 16'h0006;
    issue_start(12'h00F, 2, 1'b0, e0);
    expect_sweep(e0, 12'h00F, 2, pat, 4);
    wait_cyc(e0 + 3);
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    @(negedge clk);
    check("stop_sel_valid", 32'(sel_valid), 32'(0));
    check("stop_busy", 32'(busy), 32'(0));
    check("stop_done", 32'(done), 32'(0));
    check("stop_vec_kept", 32'(sample_vec), 32'(12'h009));
    drain();

    // Start with an empty mask is ignored
    sel_prev = sel;
    issue_start(12'h000, 2, 1'b0, e0);
    check("zmask_busy", 32'(busy), 32'(0));
    check("zmask_sel", 32'(sel), 32'(sel_prev));
    @(negedge clk);
    check("zmask_busy_later", 32'(busy), 32'(0));
    check("zmask_done", 32'(done), 32'(0));

    // Continuous sweeps, with a start and mask/dwell changes while busy
    pat = 16'h0FFF;
    issue_start(12'h801, 1, 1'b1, e0);
    expect_sweep(e0,      12'h801, 1, pat, BIG);
    expect_sweep(e0 + 7,  12'h801, 1, pat, BIG);
    expect_sweep(e0 + 14, 12'h801, 1, pat, BIG);
    expect_sweep(e0 + 21, 12'h002, 1, pat, BIG);
    wait_cyc(e0 + 2);
    start   = 1'b1;
    ch_mask = 12'h0F0;
    dwell_i = DWELL_W'(7);
    @(posedge clk);
    #1;
    start   = 1'b0;
    ch_mask = 12'h801;
    dwell_i = DWELL_W'(1);
    wait_cyc(e0 + 10);
    check("cont_busy", 32'(busy), 32'(1));
    wait_cyc(e0 + 16);
    ch_mask = 12'h002;
    wait_cyc(e0 + 24);
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    check("cont_stop_busy", 32'(busy), 32'(0));
    check("cont_stop_sel_valid", 32'(sel_valid), 32'(0));
    check("cont_stop_vec", 32'(sample_vec), 32'(12'h002));
    drain();

    // Asynchronous reset in the middle of a dwell
    pat = 16'h0004;
    issue_start(12'h005, 3, 1'b0, e0);
    expect_sweep(e0, 12'h005, 3, pat, BIG);
    wait_cyc(e0 + 2);
    #2;
    rst_n = 1'b0;
    selq.delete();
    doneq.delete();
    #1;
    check("arst_sel", 32'(sel), 32'(0));
    check("arst_sel_valid", 32'(sel_valid), 32'(0));
    check("arst_busy", 32'(busy), 32'(0));
    check("arst_done", 32'(done), 32'(0));
    check("arst_vec", 32'(sample_vec), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    issue_start(12'h005, 3, 1'b0, e0);
    expect_sweep(e0, 12'h005, 3, pat, BIG);
    drain();
    check("arst_rerun_vec", 32'(sample_vec), 32'(12'h004));

    // Randomized single-shot sweeps
    for (int it = 0; it < 8; it++) begin
      m   = NCH'($urandom_range(1, 4095));
      dw  = int'($urandom_range(0, 4));
      pat = 16'($urandom);
      issue_start(m, dw, 1'b0, e0);
      expect_sweep(e0, m, dw, pat, BIG);
      drain();
      check("rand_busy_idle", 32'(busy), 32'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/kenh_scan_seq.md
Name: kenh_scan_seq

Overview:
- Channel-scan sequencer that drives the 4-bit select of the 12-channel multiplexer stage directly downstream of it.
- Steps the select through the enabled channels and holds each one for a programmable dwell time so the mux output can settle.
- Samples bit 0 of the mux output once per channel and publishes a 12-bit snapshot at the end of every sweep.
- Supports single-shot and continuous sweeps, with a start/busy/done handshake and an abort input.

Parameters:
- NCH, 12: number of channels; must match the mux width. Legal select values are 0..NCH-1.
- SELW, 4: select width.
- DWELL_W, 8: width of the dwell count.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
- stop  in  1  abort request; honoured in any state.
- continuous  in  1  latched at start; 1 = repeat sweeps until stop.
- ch_mask  in  NCH  channel enable bits; latched at start and at each sweep wrap.
- dwell  in  DWELL_W  settle cycles per channel; latched at the same points as ch_mask.
- mux_in  in  1  bit 0 of the downstream mux output.
- sel  out  SELW  select to the mux.
- sel_valid  out  1  high while sel addresses a channel being scanned.
- sample_vec  out  NCH  last completed sweep; bit k = sampled mux_in for channel k; disabled channels read 0.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- done  out  1  one-cycle pulse when sample_vec updates.

Behaviour:
- Reset (async assert, sync release): state=IDLE, sel=0, sel_valid=0, busy=0, done=0, sample_vec=0, working vector=0, dwell counter=0.
- sel is never driven to a value >= NCH, because the mux has no default case.
- States: IDLE, DWELL, SAMPLE, DONE.
- IDLE:
  - start=1, stop=0 and ch_mask != 0: latch mask, dwell and continuous; clear the working vector; sel <= lowest enabled channel; cnt <= dwell; busy <= 1; go to DWELL.
  - start with ch_mask == 0: ignored; remain in IDLE with no done pulse.
  - start and stop in the same cycle: stop wins.
- DWELL:
  - sel_valid=1.
  - cnt == 0: go to SAMPLE. Otherwise cnt <= cnt-1.
  - DWELL therefore lasts dwell+1 cycles; dwell=0 is legal.
- SAMPLE:
  - sel_valid=1; working[sel] <= mux_in.
  - If an enabled channel above sel exists: sel <= that channel; cnt <= latched dwell; go to DWELL.
  - Otherwise go to DONE.
- Per-channel cost is dwell+2 cycles.
- DONE:
  - Lasts one cycle; done=1; sample_vec <= working; sel_valid=0.
  - continuous=1: re-latch ch_mask and dwell, clear the working vector, then go to DWELL on the new lowest enabled channel. If the new mask is 0, go to IDLE with busy <= 0.
  - continuous=0: go to IDLE; busy <= 0 in the same edge.
- Timing: start accepted at edge 0 gives the first DWELL in cycle 1. With N enabled channels, done is high in cycle N*(dwell+2)+1. Continuous sweep period is N*(dwell+2)+1.
- stop:
  - In DWELL, SAMPLE or DONE: go to IDLE next edge; sel_valid <= 0; busy <= 0; no done pulse; sample_vec retains the previous completed sweep.
  - If stop coincides with DONE, the done pulse and sample_vec update in that cycle still occur.
- start while busy is ignored. Changes to ch_mask or dwell mid-sweep have no effect until the next latch point.
- sel holds its last value in IDLE.
- Reset asserted mid-sweep immediately forces all reset values, including sample_vec=0.

Decomposition:
- Shared package kenh_pkg holds:
  - NCH, SELW, DWELL_W constants.
  - State enum: IDLE, DWELL, SAMPLE, DONE.
  - Mask type.
- One combinational sub-module, kenh_next_find:
  - Inputs: mask, cur.
  - Outputs: first (lowest set bit), next (lowest set bit above cur), has_next, any.
  - Fixed-priority search, so it is reusable by other scanners.

Test Plan:
- Single-shot, ch_mask=0x005, dwell=3, mux_in = 1 when sel==2 else 0, start at edge 0 -> sel=0 in cycles 1-5, sel=2 in cycles 6-10, done high only in cycle 11, sample_vec=0x004, busy low from cycle 12.
- ch_mask=0xFFF, dwell=0, mux_in = sel[0] -> sel walks 0..11 two cycles each, never 12-15; done in cycle 25; sample_vec=0xAAA.
- Continuous, ch_mask=0x801, dwell=1, mux_in=1 -> done pulses in cycles 7, 14, 21; busy stays 1; change ch_mask to 0x002 before cycle 7 -> next sweep scans only channel 1 and sample_vec=0x002 at cycle 11.
- stop asserted in cycle 4 of a 0x00F, dwell=2 sweep after one prior completed sweep with sample_vec=0x009 -> IDLE at cycle 5, no done, sample_vec stays 0x009, sel_valid=0.
- start with ch_mask=0 -> no state change, busy=0, done=0. start while busy -> ignored, sweep timing unchanged.
- rst_n pulled low asynchronously mid-DWELL -> all outputs reset without a clock edge; a fresh start after release behaves as in the first scenario.
